// File: rtl/c3lib_ckact_det.sv
// c3lib_ckact_det: clock activity detector for a c3lib clock path.
// Counts synchronized mon_clk rising edges per window and reports alive/fast.
module c3lib_ckact_det #(
  parameter int SYNC_STAGES  = 2,
  parameter int WIN_CYCLES   = 64,
  parameter int CNT_W        = 8,
  parameter int MIN_EDGES    = 4,
  parameter int MAX_EDGES    = 30,
  parameter int LOSS_WINDOWS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mon_clk,
  output logic             clk_alive,
  output logic             clk_fast,
  output logic             meas_done,
  output logic [CNT_W-1:0] edge_cnt
);

  localparam int WIN_W  = $clog2(WIN_CYCLES);
  localparam int LOSS_W = $clog2(LOSS_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_PRE  = WIN_W'(WIN_CYCLES - 2);
  localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_EDGES);
  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_WINDOWS);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_q;
  logic                   edge_p;
  logic [WIN_W-1:0]       win;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [LOSS_W-1:0]      low;
  logic [LOSS_W-1:0]      low_nxt;
  logic                   good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      sync_q <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], mon_clk};
      sync_q <= sync[SYNC_STAGES-1];
      edge_p <= sync[SYNC_STAGES-1] & ~sync_q;
    end
  end

  assign cnt_inc = (edge_p && cnt != '1) ? cnt + 1'b1 : cnt;
  assign good    = cnt_inc >= MIN_C;
  assign low_nxt = (low == LOSS_MAX) ? low : low + 1'b1;

  // meas_done is set one cycle early so it is high during the last window cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      win       <= '0;
      cnt       <= '0;
      low       <= '0;
      meas_done <= 1'b0;
      edge_cnt  <= '0;
      clk_alive <= 1'b0;
      clk_fast  <= 1'b0;
    end else begin
      meas_done <= 1'b0;
      case (state)
        IDLE: begin
          win <= '0;
          cnt <= '0;
          if (enable) state <= MEASURE;
        end
        MEASURE: begin
          if (win == WIN_LAST) begin
            edge_cnt <= cnt_inc;
            clk_fast <= cnt_inc > MAX_C;
            cnt      <= '0;
            win      <= '0;
            if (good) begin
              clk_alive <= 1'b1;
              low       <= '0;
            end else begin
              low <= low_nxt;
              if (low_nxt == LOSS_MAX) clk_alive <= 1'b0;
            end
            if (!enable) state <= IDLE;
          end else if (!enable) begin
            state <= IDLE;
            win   <= '0;
            cnt   <= '0;
          end else begin
            win       <= win + 1'b1;
            cnt       <= cnt_inc;
            meas_done <= (win == WIN_PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/c3lib_ckact_det.md
Name: c3lib_ckact_det

Overview:
- Clock activity detector placed at the receiving end of a c3lib clock path, e.g. downstream of a ckinv/ckbuf tree or at a forwarded-clock input.
- Treats the monitored clock as asynchronous data: synchronizes it into the reference clock domain, counts its rising edges over a fixed window, and reports alive/dead/too-fast status.
- Used by link bring-up and watchdog logic to qualify a clock before downstream resets are released.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on mon_clk; legal range 2..4.
- WIN_CYCLES, 64, reference cycles per measurement window; must be ≥ 4.
- CNT_W, 8, edge counter width; must satisfy 2^CNT_W > WIN_CYCLES/2.
- MIN_EDGES, 4, minimum edges per window for the window to be "good".
- MAX_EDGES, 30, maximum edges per window; more than this sets the fast flag.
- LOSS_WINDOWS, 2, consecutive low windows required to deassert clk_alive.

Ports:
- clk, input, 1, reference clock.
- rst, input, 1, asynchronous active-high reset.
- enable, input, 1, measurement enable; synchronous level.
- mon_clk, input, 1, monitored clock, asynchronous to clk.
- clk_alive, output, 1, monitored clock qualified as present.
- clk_fast, output, 1, last window exceeded MAX_EDGES.
- meas_done, output, 1, one-cycle pulse at each window end.
- edge_cnt, output, CNT_W, edge count of the last completed window.

Behaviour:
- Reset (async assert, release on clk): all synchronizer flops, edge-detect flop, counters and outputs go to 0. State is IDLE.
- Synchronizer: SYNC_STAGES flops. Edge detect compares the last sync stage with one extra flop; an edge pulse is registered for a 0→1 transition. A mon_clk rising edge is counted no earlier than SYNC_STAGES+1 clk cycles after it occurs.
- FSM states:
  - IDLE: window counter and edge counter held at 0. Outputs hold their last values. Goes to MEASURE on the first cycle enable=1.
  - MEASURE: window counter increments from 0 to WIN_CYCLES-1. The edge counter increments on each edge pulse and saturates at all-ones.
  - Window end, i.e. the cycle the window counter equals WIN_CYCLES-1:
    - meas_done=1 for exactly that cycle.
    - edge_cnt is loaded with the final count, including any edge pulse in that same cycle.
    - The edge counter restarts at 0; an edge pulse in that cycle belongs to the ending window.
    - Remains in MEASURE, so windows are back-to-back.
  - enable=0 in MEASURE: the partial window is discarded with no meas_done and no status update. Goes to IDLE next cycle and the synchronizer keeps running.
- Status update at window end (registered, visible the cycle after meas_done):
  - good = count ≥ MIN_EDGES.
  - If good, clk_alive goes to 1 and the low-window counter clears.
  - If not good, the low-window counter increments, saturating at LOSS_WINDOWS. When it reaches LOSS_WINDOWS, clk_alive goes to 0.
  - clk_fast = (count > MAX_EDGES), updated every window.
- clk_alive may assert after a single good window; there is no hysteresis on assert.
- A mon_clk faster than clk/2 aliases. This is out of scope; with the required 2-flop synchronizer the count is undefined but bounded by saturation.
- rst asserted mid-window: everything returns to reset values immediately. There is no meas_done for the aborted window.

Test Plan:
- Reset behaviour: rst=1 with mon_clk toggling → all outputs 0, no meas_done. After release with enable=0 for 100 cycles → outputs stay 0.
- mon_clk = clk/4 (rising edge every 4 cycles), enable=1, defaults → meas_done every 64 cycles; edge_cnt=16 (±1 for the first window); clk_alive=1 the cycle after the first meas_done; clk_fast=0.
- Clock loss: mon_clk held 0 after alive → edge_cnt=0 on the next windows; clk_alive stays 1 after the first bad window and drops the cycle after the second meas_done.
- Fast clock: mon_clk = clk/2, MAX_EDGES=30 → edge_cnt=32, clk_fast=1, clk_alive=1. Switching mon_clk to clk/4 → clk_fast=0 after the next window.
- Edge at window boundary: force a single synchronized edge pulse in cycle 63 → counted in the ending window (edge_cnt=1); the next window starts at 0.
- Abort cases:
  - enable dropped at window cycle 30 → no meas_done; edge_cnt and clk_alive unchanged; re-enable starts a fresh 64-cycle window.
  - rst pulsed mid-window → outputs cleared asynchronously.
